program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 15 +
 rtl/program_loader.sv | 100 ++++++++++
 tb/tb_program_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared FSM encoding and default widths for the program loader
package program_loader_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader.sv
// program_loader: streams LOAD_COUNT upstream bytes into memory with setup/strobe/hold write cycles; LOADER_CHECKSUM_EN adds a running byte checksum output
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOAD_COUNT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              write_enable,
    output logic              enable,
    output logic              busy,
    output logic              done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_COUNT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              clear;

    assign enable = 1'b1;

    // next state, next address/data; start is honoured only in IDLE and DONE
    always_comb begin
        state_d = state_q;
        addr_d  = address;
        data_d  = data;
        clear   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    clear   = 1'b1;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    state_d = WRITE;
                    data_d  = in_data;
                end
            end
            WRITE: state_d = HOLD;
            HOLD: begin
                state_d = (address == LAST) ? DONE : LOAD;
                addr_d  = (address == LAST) ? address : address + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and every output registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            address      <= '0;
            data         <= '0;
            in_ready     <= 1'b0;
            write_enable <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            address      <= addr_d;
            data         <= data_d;
            in_ready     <= (state_d == LOAD);
            write_enable <= (state_d != WRITE);
            busy         <= (state_d == LOAD) || (state_d == WRITE) || (state_d == HOLD);
            done         <= (state_d == DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // running modulo-2^DATA_W sum of accepted bytes, cleared on each start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (clear) begin
            checksum <= '0;
        end else if (state_q == LOAD && in_valid) begin
            checksum <= checksum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader with a 16x8 memory model
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [3:0] address;
    logic [7:0] data;
    logic       write_enable;
    logic       enable;
    logic       busy;
    logic       done;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int         total = 0;
    int         passes = 0;
    int         wr_cnt = 0;
    int         base;
    logic [7:0] mem [16];
    logic [3:0] addr_log [256];

    program_loader #(.ADDR_W(4), .DATA_W(8), .LOAD_COUNT(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .address(address),
        .data(data),
        .write_enable(write_enable),
        .enable(enable),
        .busy(busy),
        .done(done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // memory model: captures a write on every edge where the strobe is low
    always @(posedge clk) begin
        if (rst_n && write_enable == 1'b0) begin
            mem[address]     <= data;
            addr_log[wr_cnt] <= address;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
        check("accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_load();
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_done", 32'(done), 32'd0);
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_addr", 32'(address), 32'd15);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_we", 32'(write_enable), 32'd1);
        check("rst_en", 32'(enable), 32'd1);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_nowrite", 32'(wr_cnt), 32'd0);
        in_valid = 1'b0;

        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        check("load_ready", 32'(in_ready), 32'd1);
        check("load_addr", 32'(address), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        finish_load();
        check("full_count", 32'(wr_cnt), 32'd16);
        for (int i = 0; i < 16; i++) check("full_addr", 32'(addr_log[i]), 32'(i));
        for (int i = 0; i < 16; i++) check("full_mem", 32'(mem[i]), 32'(i));

        base = wr_cnt;
        pulse_start();
        check("reload_done", 32'(done), 32'd0);
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b0;
        in_data = 8'hAA;
        for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("stall_addr", 32'(address), 32'd2);
        check("stall_ready", 32'(in_ready), 32'd1);
        check("stall_nowrite", 32'(wr_cnt - base), 32'd2);
        send_byte(8'hCC);
        for (int i = 3; i < 16; i++) begin
            send_byte(8'(8'h30 + i));
            if (i == 7) begin
                in_valid = 1'b0;
                start = 1'b1;
                repeat (4) @(negedge clk);
                start = 1'b0;
                check("ign_start_addr", 32'(address), 32'd8);
            end
        end
        finish_load();
        check("load2_count", 32'(wr_cnt - base), 32'd16);
        for (int i = 0; i < 16; i++) check("load2_addr", 32'(addr_log[base + i]), 32'(i));
        check("mem0", 32'(mem[0]), 32'h11);
        check("mem2", 32'(mem[2]), 32'hCC);
        check("mem15", 32'(mem[15]), 32'h3F);

        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h50 + i));
        check("mid_we_low", 32'(write_enable), 32'd0);
        check("mid_addr", 32'(address), 32'd5);
        rst_n = 1'b0;
        #1;
        check("mid_we_async", 32'(write_enable), 32'd1);
        check("mid_addr_rst", 32'(address), 32'd0);
        check("mid_busy_rst", 32'(busy), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        base = wr_cnt;
        pulse_start();
        check("post_rst_addr", 32'(address), 32'd0);
        send_byte(8'h77);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_count", 32'(wr_cnt - base), 32'd1);
        check("post_rst_waddr", 32'(addr_log[base]), 32'd0);
        check("post_rst_mem", 32'(mem[0]), 32'h77);

`ifdef LOADER_CHECKSUM_EN
        for (int k = 0; k < 60 && !in_ready; k++) @(negedge clk);
        for (int i = 1; i < 16; i++) send_byte(8'h00);
        finish_load();
        pulse_start();
        check("cks_clear", 32'(checksum), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'hFF);
        finish_load();
        check("cks_final", 32'(checksum), 32'hF0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
